// File: rtl/interconn_sender.sv
// Transmit-side packer for one crossbar sender slot: gathers K = W/DW elements
// into a W-bit word and emits it as a single-cycle registered send_en pulse.
module interconn_sender #(
    parameter int W     = 128,
    parameter int DW    = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic             send_en,
    output logic [W-1:0]     send_word,
    output logic             busy,
    output logic             done,
    output logic             state_dbg
);

    localparam int K  = W / DW;
    localparam int LW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Handshake: an element transfers on a rising edge where in_valid & in_ready;
    // in_ready depends only on state, never on in_valid.
    state_t           state, state_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic [LW-1:0]    lane, lane_n;
    logic [W-1:0]     pack, pack_n, merged, send_word_n;
    logic             send_en_n, done_n;

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN);
    assign state_dbg = (state == RUN);

    // Pack register with the incoming element dropped into the current lane.
    always_comb begin
        merged = pack;
        for (int i = 0; i < K; i++) begin
            if (lane == LW'(i)) merged[i*DW +: DW] = in_data;
        end
    end

    always_comb begin
        state_n     = state;
        rem_n       = rem;
        lane_n      = lane;
        pack_n      = pack;
        send_en_n   = 1'b0;
        send_word_n = send_word;
        done_n      = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && start) begin
                    if (len != '0) begin
                        state_n = RUN;
                        rem_n   = len;
                        lane_n  = '0;
                        pack_n  = '0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Cancel wins over a simultaneous accept; the partial word is dropped.
                    state_n = IDLE;
                    rem_n   = '0;
                    lane_n  = '0;
                    pack_n  = '0;
                end else if (in_valid) begin
                    rem_n = rem - LEN_W'(1);
                    if (lane == LW'(K - 1) || rem == LEN_W'(1)) begin
                        send_en_n   = 1'b1;
                        send_word_n = merged;
                        pack_n      = '0;
                        lane_n      = '0;
                    end else begin
                        pack_n = merged;
                        lane_n = lane + LW'(1);
                    end
                    if (rem == LEN_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            rem       <= '0;
            lane      <= '0;
            pack      <= '0;
            send_en   <= 1'b0;
            send_word <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            rem       <= rem_n;
            lane      <= lane_n;
            pack      <= pack_n;
            send_en   <= send_en_n;
            send_word <= send_word_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_interconn_sender.sv
// Directed table-driven bench for interconn_sender (W=128, DW=32, K=4).
module tb_interconn_sender;

    localparam int W = 128;
    localparam int DW = 32;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             send_en;
    logic [W-1:0]     send_word;
    logic             busy;
    logic             done;
    logic             state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic             start;
        logic [LEN_W-1:0] len;
        logic             abort;
        logic             vld;
        logic [DW-1:0]    data;
        logic             rdy;
        logic             busy;
        logic             sen;
        logic             done;
        logic [W-1:0]     word;
    } vec_t;

    vec_t tbl[$];

    interconn_sender #(.W(W), .DW(DW), .LEN_W(LEN_W)) dut (
        .clk(clk), .clr(clr), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .send_en(send_en), .send_word(send_word), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] w4(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic vec_t mk(input logic st, input logic [LEN_W-1:0] ln, input logic ab,
                                input logic v, input logic [DW-1:0] dt, input logic r,
                                input logic b, input logic s, input logic dn,
                                input logic [W-1:0] wd);
        vec_t x;
        x.start = st; x.len = ln; x.abort = ab; x.vld = v; x.data = dt;
        x.rdy = r; x.busy = b; x.sen = s; x.done = dn; x.word = wd;
        return x;
    endfunction

    task automatic add(input logic st, input logic [LEN_W-1:0] ln, input logic ab,
                       input logic v, input logic [DW-1:0] dt, input logic r,
                       input logic b, input logic s, input logic dn,
                       input logic [W-1:0] wd);
        tbl.push_back(mk(st, ln, ab, v, dt, r, b, s, dn, wd));
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " in_ready"}, W'(in_ready), W'(v.rdy));
        chk({tag, " busy"}, W'(busy), W'(v.busy));
        chk({tag, " state_dbg"}, W'(state_dbg), W'(v.busy));
        chk({tag, " send_en"}, W'(send_en), W'(v.sen));
        chk({tag, " done"}, W'(done), W'(v.done));
        chk({tag, " send_word"}, send_word, v.word);
    endtask

    // Drive one cycle of inputs, clock once, then compare the post-edge outputs.
    task automatic run_vec(input string tag, input vec_t v);
        start = v.start; len = v.len; abort = v.abort;
        in_valid = v.vld; in_data = v.data;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    initial begin
        logic [W-1:0] cw;
        logic [W-1:0] w1, w2, w3, w5, wb, wc;

        w1 = w4(32'd1, 32'd2, 32'd3, 32'd4);
        w2 = w4(32'd5, 32'd6, 32'd7, 32'd8);
        w3 = w4(32'd5, 32'd6, 32'd0, 32'd0);
        w5 = w4(32'd5, 32'd0, 32'd0, 32'd0);
        wb = w4(32'hb1, 32'hb2, 32'hb3, 32'hb4);
        wc = w4(32'h21, 32'h22, 32'h23, 32'h24);

        // Reset idle
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        // len=8 back-to-back
        add(1, 8, 0, 0, 0, 1, 1, 0, 0, '0);
        for (int k = 1; k <= 3; k++) add(0, 0, 0, 1, DW'(k), 1, 1, 0, 0, '0);
        add(0, 0, 0, 1, 4, 1, 1, 1, 0, w1);
        for (int k = 5; k <= 7; k++) add(0, 0, 0, 1, DW'(k), 1, 1, 0, 0, w1);
        add(0, 0, 0, 1, 8, 0, 0, 1, 1, w2);
        add(0, 0, 0, 1, 99, 0, 0, 0, 0, w2);
        // len=6 with in_valid toggling
        add(1, 6, 0, 0, 0, 1, 1, 0, 0, w2);
        cw = w2;
        for (int k = 1; k <= 6; k++) begin
            add(0, 0, 0, 0, 32'hdead, 1, 1, 0, 0, cw);
            if (k == 4) begin
                cw = w1;
                add(0, 0, 0, 1, DW'(k), 1, 1, 1, 0, cw);
            end else if (k == 6) begin
                cw = w3;
                add(0, 0, 0, 1, DW'(k), 0, 0, 1, 1, cw);
            end else begin
                add(0, 0, 0, 1, DW'(k), 1, 1, 0, 0, cw);
            end
        end
        // len=0, then abort-in-idle beating start
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, w3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, w3);
        add(1, 4, 1, 0, 0, 0, 0, 0, 0, w3);
        // start len=3 mid-transfer is ignored
        add(1, 5, 0, 0, 0, 1, 1, 0, 0, w3);
        add(0, 0, 0, 1, 1, 1, 1, 0, 0, w3);
        add(1, 3, 0, 1, 2, 1, 1, 0, 0, w3);
        add(0, 0, 0, 1, 3, 1, 1, 0, 0, w3);
        add(0, 0, 0, 1, 4, 1, 1, 1, 0, w1);
        add(0, 0, 0, 1, 5, 0, 0, 1, 1, w5);
        // abort after 2 of 4, simultaneous element dropped, then clean transfer
        add(1, 4, 0, 0, 0, 1, 1, 0, 0, w5);
        add(0, 0, 0, 1, 32'ha1, 1, 1, 0, 0, w5);
        add(0, 0, 0, 1, 32'ha2, 1, 1, 0, 0, w5);
        add(0, 0, 1, 1, 32'ha3, 0, 0, 0, 0, w5);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, w5);
        add(1, 4, 0, 0, 0, 1, 1, 0, 0, w5);
        add(0, 0, 0, 1, 32'hb1, 1, 1, 0, 0, w5);
        add(0, 0, 0, 1, 32'hb2, 1, 1, 0, 0, w5);
        add(0, 0, 0, 1, 32'hb3, 1, 1, 0, 0, w5);
        add(0, 0, 0, 1, 32'hb4, 0, 0, 1, 1, wb);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, wb);

        clr = 1'b1; start = 0; len = '0; abort = 0; in_valid = 0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        clr = 1'b0;

        for (int i = 0; i < tbl.size(); i++) run_vec($sformatf("row%0d", i), tbl[i]);

        // clr between element 3 and 4
        run_vec("clr_start", mk(1, 4, 0, 0, 0, 1, 1, 0, 0, wb));
        run_vec("clr_e1", mk(0, 0, 0, 1, 32'h31, 1, 1, 0, 0, wb));
        run_vec("clr_e2", mk(0, 0, 0, 1, 32'h32, 1, 1, 0, 0, wb));
        run_vec("clr_e3", mk(0, 0, 0, 1, 32'h33, 1, 1, 0, 0, wb));
        in_valid = 1'b0;
        clr = 1'b1;
        #1;
        check_outs("clr_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        @(posedge clk);
        #1;
        check_outs("clr_held", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        clr = 1'b0;
        run_vec("post_clr_start", mk(1, 4, 0, 0, 0, 1, 1, 0, 0, '0));
        run_vec("post_clr_e1", mk(0, 0, 0, 1, 32'h21, 1, 1, 0, 0, '0));
        run_vec("post_clr_e2", mk(0, 0, 0, 1, 32'h22, 1, 1, 0, 0, '0));
        run_vec("post_clr_e3", mk(0, 0, 0, 1, 32'h23, 1, 1, 0, 0, '0));
        run_vec("post_clr_e4", mk(0, 0, 0, 1, 32'h24, 0, 0, 1, 1, wc));
        run_vec("post_clr_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, wc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
